// File: rtl/speed_counter_mc.sv
// speed_counter_mc: multi-channel gated pulse counter with sequential double-dabble BCD readout.
// Optional build macro COUNT_SAT_EN: saturating live counters with a sticky overflow bit on ovf.
module speed_counter_mc #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 11,
  parameter int BCD_DIGITS = 3,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_test,
  input  logic                    reset,
  input  logic                    gate,
  input  logic                    clr_count,
  input  logic [NUM_CH-1:0]       pulse_in,
  input  logic                    conv_ready,
  output logic                    bcd_valid,
  output logic [CH_W-1:0]         bcd_ch,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    ovf,
  output logic                    busy
);
  localparam int BW   = 4 * BCD_DIGITS;
  localparam int BC_W = $clog2(CNT_W + 1);
  localparam logic [31:0] BCD_MAX = (32'd10 ** BCD_DIGITS) - 32'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    PRESENT = 2'd3
  } state_t;

  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      else                     r[4*d +: 4] = r[4*d +: 4];
    end
    return r;
  endfunction

  logic [NUM_CH-1:0] sync1_r, sync2_r, sync3_r, edge_s;
  logic              gate_d_r, fall_s, accept_s;
  logic [CNT_W-1:0]  cnt_r  [NUM_CH];
  logic [CNT_W-1:0]  snap_r [NUM_CH];
  state_t            state_r, state_s;
  logic [CH_W-1:0]   ch_r, ld_ch_s;
  logic              load_s, xfer_s, last_bit_s;
  logic [BC_W-1:0]   bit_r;
  logic [CNT_W-1:0]  shift_r;
  logic [BW-1:0]     acc_r, adj_s, acc_next_s;
  logic              range_r;
`ifdef COUNT_SAT_EN
  logic [NUM_CH-1:0] sat_r, snap_sat_r;
`endif

  assign edge_s     = sync2_r & ~sync3_r;
  assign fall_s     = gate_d_r & ~gate;
  assign accept_s   = fall_s & (state_r == IDLE);
  assign adj_s      = dd_adjust(acc_r);
  assign acc_next_s = {adj_s[BW-2:0], shift_r[CNT_W-1]};
  assign last_bit_s = (bit_r == BC_W'(CNT_W - 1));

  // Pulse synchronisers (third stage is the edge-detect history) and gate history.
  always_ff @(posedge clk_test or posedge reset) begin
    if (reset) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      sync3_r  <= '0;
      gate_d_r <= 1'b0;
    end else begin
      sync1_r  <= pulse_in;
      sync2_r  <= sync1_r;
      sync3_r  <= sync2_r;
      gate_d_r <= gate;
    end
  end

  // Live counters: any gate fall clears them, even when the window is discarded.
  always_ff @(posedge clk_test or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) cnt_r[c] <= '0;
`ifdef COUNT_SAT_EN
      sat_r <= '0;
`endif
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_count || fall_s) begin
          cnt_r[c] <= '0;
`ifdef COUNT_SAT_EN
          sat_r[c] <= 1'b0;
`endif
        end else if (gate && edge_s[c]) begin
`ifdef COUNT_SAT_EN
          if (cnt_r[c] == {CNT_W{1'b1}}) sat_r[c] <= 1'b1;
          else                          cnt_r[c] <= cnt_r[c] + CNT_W'(1);
`else
          cnt_r[c] <= cnt_r[c] + CNT_W'(1);
`endif
        end
      end
    end
  end

  // Snapshot bank, captured only on an accepted gate fall.
  always_ff @(posedge clk_test or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) snap_r[c] <= '0;
`ifdef COUNT_SAT_EN
      snap_sat_r <= '0;
`endif
    end else if (accept_s) begin
      for (int c = 0; c < NUM_CH; c++) snap_r[c] <= cnt_r[c];
`ifdef COUNT_SAT_EN
      snap_sat_r <= sat_r;
`endif
    end
  end

  // Conversion state register.
  always_ff @(posedge clk_test or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next state; a transfer with channels remaining loads the next one directly.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    xfer_s  = 1'b0;
    ld_ch_s = ch_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = LOAD;
        else          state_s = IDLE;
      end
      LOAD: begin
        load_s  = 1'b1;
        state_s = SHIFT;
      end
      SHIFT: begin
        if (last_bit_s) state_s = PRESENT;
        else            state_s = SHIFT;
      end
      PRESENT: begin
        if (conv_ready) begin
          xfer_s = 1'b1;
          if (ch_r == CH_W'(NUM_CH - 1)) begin
            state_s = IDLE;
          end else begin
            load_s  = 1'b1;
            ld_ch_s = ch_r + CH_W'(1);
            state_s = SHIFT;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Double-dabble datapath and registered result outputs.
  always_ff @(posedge clk_test or posedge reset) begin
    if (reset) begin
      ch_r      <= '0;
      bit_r     <= '0;
      shift_r   <= '0;
      acc_r     <= '0;
      range_r   <= 1'b0;
      bcd_valid <= 1'b0;
      bcd_ch    <= '0;
      bcd_out   <= '0;
      busy      <= 1'b0;
`ifdef COUNT_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        ch_r <= '0;
        busy <= 1'b1;
      end
      if (load_s) begin
        ch_r    <= ld_ch_s;
        shift_r <= snap_r[ld_ch_s];
        acc_r   <= '0;
        bit_r   <= '0;
        range_r <= (32'(snap_r[ld_ch_s]) > BCD_MAX);
      end else if (state_r == SHIFT) begin
        shift_r <= shift_r << 1;
        acc_r   <= acc_next_s;
        bit_r   <= bit_r + BC_W'(1);
        if (last_bit_s) begin
          bcd_valid <= 1'b1;
          bcd_ch    <= ch_r;
          bcd_out   <= range_r ? {BCD_DIGITS{4'h9}} : acc_next_s;
`ifdef COUNT_SAT_EN
          ovf       <= snap_sat_r[ch_r];
`endif
        end
      end
      if (xfer_s) begin
        bcd_valid <= 1'b0;
`ifdef COUNT_SAT_EN
        ovf       <= 1'b0;
`endif
        if (state_s == IDLE) busy <= 1'b0;
      end
    end
  end

`ifndef COUNT_SAT_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_speed_counter_mc.sv
// tb_speed_counter_mc: randomized bench; a behavioural model (edge tallies, decimal digits,
// expected-result queue with cycle schedule) is compared against the DUT every cycle.
module tb_speed_counter_mc;
  localparam int NUM_CH     = 2;
  localparam int CNT_W      = 11;
  localparam int BCD_DIGITS = 3;
  localparam int CH_W       = 1;
  localparam int BW         = 12;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int BCD_MAX    = 10 ** BCD_DIGITS - 1;

  logic              clk_test = 1'b0;
  logic              reset = 1'b1;
  logic              gate = 1'b0;
  logic              clr_count = 1'b0;
  logic              conv_ready = 1'b1;
  logic [NUM_CH-1:0] pulse_in = '0;
  logic              bcd_valid, ovf, busy;
  logic [CH_W-1:0]   bcd_ch;
  logic [BW-1:0]     bcd_out;

  speed_counter_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BCD_DIGITS(BCD_DIGITS)) dut (
    .clk_test(clk_test), .reset(reset), .gate(gate), .clr_count(clr_count),
    .pulse_in(pulse_in), .conv_ready(conv_ready), .bcd_valid(bcd_valid),
    .bcd_ch(bcd_ch), .bcd_out(bcd_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk_test = ~clk_test;

  typedef struct {
    int ch;
    int bcd;
    int ov;
  } res_t;

  res_t pend[$];
  int   live[NUM_CH];
  int   sat[NUM_CH];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   present_at = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int to_bcd(input int v);
    int r = 0;
    int x = (v > BCD_MAX) ? BCD_MAX : v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_rise(input int c);
`ifdef COUNT_SAT_EN
    if (live[c] == CNT_MAX) sat[c] = 1;
    else                    live[c] = live[c] + 1;
`else
    live[c] = (live[c] + 1) % (CNT_MAX + 1);
`endif
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      live[c] = 0;
      sat[c]  = 0;
    end
  endtask

  // Ready driver: forced level or random.
  initial begin
    forever begin
      @(posedge clk_test);
      #1;
      conv_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Compare process: model schedule vs DUT outputs every cycle.
  initial begin
    bit prev_gate;
    bit idle;
    bit exp_valid;
    res_t r;
    prev_gate = 1'b0;
    forever begin
      @(negedge clk_test);
      cyc++;
      if (reset) begin
        prev_gate = 1'b0;
      end else begin
        idle      = (pend.size() == 0);
        exp_valid = !idle && (cyc >= present_at);
        check("bcd_valid", 32'(bcd_valid), 32'(exp_valid));
        check("busy", 32'(busy), 32'(!idle));
        if (exp_valid) begin
          check("bcd_ch", 32'(bcd_ch), pend[0].ch);
          check("bcd_out", 32'(bcd_out), pend[0].bcd);
          check("ovf", 32'(ovf), pend[0].ov);
          if (conv_ready) begin
            void'(pend.pop_front());
            if (pend.size() > 0) present_at = cyc + CNT_W + 1;
          end
        end
        if (prev_gate && !gate) begin
          if (idle) begin
            for (int c = 0; c < NUM_CH; c++) begin
              r.ch  = c;
              r.bcd = to_bcd(live[c]);
              r.ov  = sat[c];
              pend.push_back(r);
            end
            present_at = cyc + CNT_W + 2;
          end
          model_clear();
        end
        prev_gate = gate;
      end
    end
  end

  task automatic tick();
    @(posedge clk_test);
    #1;
  endtask

  task automatic pulses(input int n0, input int n1);
    int rem[NUM_CH];
    rem[0] = n0;
    rem[1] = n1;
    while (rem[0] > 0 || rem[1] > 0 || pulse_in != '0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pulse_in[c]) begin
          pulse_in[c] = 1'b0;
        end else if (rem[c] > 0 && $urandom_range(0, 3) != 0) begin
          pulse_in[c] = 1'b1;
          rem[c]--;
          model_rise(c);
        end
      end
      tick();
    end
  endtask

  // One measurement window; lit0 >= 0 pins ch0's result and its exact latency.
  task automatic window(input int n0, input int n1, input bit clr_fall, input int lit0, input int lit_ovf);
    gate = 1'b1;
    tick();
    tick();
    pulses(n0, n1);
    repeat (5) tick();
    gate = 1'b0;
    clr_count = clr_fall;
    tick();
    clr_count = 1'b0;
    if (lit0 >= 0) begin
      repeat (11) tick();
      #3;
      check("lat_pre", 32'(bcd_valid), 32'd0);
      tick();
      #3;
      check("lat_valid", 32'(bcd_valid), 32'd1);
      check("lit_ch", 32'(bcd_ch), 32'd0);
      check("lit_bcd", 32'(bcd_out), lit0);
      check("lit_ovf", 32'(ovf), lit_ovf);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((pend.size() != 0 || busy) && k < 3000) begin
      tick();
      k++;
    end
    check("idle_reached", 32'(k < 3000), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(bcd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    window(137, 5, 1'b0, 'h137, 0);
    wait_idle();

    rdy_force = 1'b0;
    window(137, 5, 1'b0, 'h137, 0);
    repeat (40) tick();
    rdy_force = 1'b1;
    wait_idle();

    window(1500, 0, 1'b0, 'h999, 0);
    wait_idle();
`ifdef COUNT_SAT_EN
    window(2100, 3, 1'b0, 'h999, 1);
`else
    window(2100, 3, 1'b0, 'h052, 0);
`endif
    wait_idle();

    window(42, 9, 1'b1, 'h042, 0);
    wait_idle();
    window(7, 3, 1'b0, 'h007, 0);
    wait_idle();

    // clr_count in the middle of a window discards earlier edges
    gate = 1'b1;
    repeat (2) tick();
    pulses(30, 12);
    repeat (4) tick();
    clr_count = 1'b1;
    model_clear();
    tick();
    clr_count = 1'b0;
    pulses(11, 4);
    repeat (5) tick();
    gate = 1'b0;
    tick();
    wait_idle();

    // second gate fall while the first window is still converting
    window(20, 3, 1'b0, -1, 0);
    repeat (2) tick();
    gate = 1'b1;
    tick();
    pulse_in = 2'b11;
    model_rise(0);
    model_rise(1);
    tick();
    pulse_in = 2'b00;
    repeat (4) tick();
    gate = 1'b0;
    tick();
    wait_idle();
    window(7, 2, 1'b0, 'h007, 0);
    wait_idle();

    // reset mid-conversion
    window(55, 6, 1'b0, -1, 0);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bcd_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    pend.delete();
    model_clear();
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    window(19, 8, 1'b0, 'h019, 0);
    wait_idle();

    rdy_rand = 1'b1;
    window(int'($urandom_range(1000, 2047)), int'($urandom_range(0, 50)), 1'b0, -1, 0);
    wait_idle();
    for (int i = 0; i < 7; i++) begin
      window(int'($urandom_range(0, 400)), int'($urandom_range(0, 400)), 1'b0, -1, 0);
      wait_idle();
    end
    rdy_rand = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
